argmax_readout_ctrl: RTL and testbench
======================================

Name: argmax_readout_ctrl

Overview:
- Sequences the readout argmax stage over the FCC output matrix (FEATURE_ROWS nodes x WEIGHT_COLS classes).
- For each node row it reads every class score from the FCC output memory, which is synchronous with 1-cycle read latency.
- It tracks the running signed maximum and writes the winning class index to the max-address memory.
- Sits between the FCC output buffer and the readout result memory; started by the top-level GCN controller.

Parameters:
- FEATURE_ROWS, 6, number of node rows to process.
- WEIGHT_COLS, 3, number of class scores per row.
- DOT_PROD_WIDTH, 16, width of each signed (two's complement) score.
- MAX_ADDRESS_WIDTH, 2, width of the stored class index; must be >= $clog2(WEIGHT_COLS).
- COUNTER_FEATURE_WIDTH, $clog2(FEATURE_ROWS), row counter and address width.
- COUNTER_WEIGHT_WIDTH, $clog2(WEIGHT_COLS), column counter and address width.

Ports:
- clk  in  1  clock; all flops rise-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a pass; sampled only in IDLE or DONE.
- rd_en  out  1  FCC memory read strobe.
- rd_row  out  COUNTER_FEATURE_WIDTH  row address of the read.
- rd_col  out  COUNTER_WEIGHT_WIDTH  column address of the read.
- rd_data  in  DOT_PROD_WIDTH  signed score; valid the cycle after rd_en.
- wr_en  out  1  max-address memory write strobe.
- wr_addr  out  COUNTER_FEATURE_WIDTH  row being written.
- wr_data  out  MAX_ADDRESS_WIDTH  argmax column index for that row.
- busy  out  1  high from the cycle after start acceptance until entry to DONE.
- done  out  1  level; high while in DONE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; row and col counters 0; running max 0; argmax index 0.
  - rd_en=0, rd_row=0, rd_col=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
- States: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE: all strobes 0. start=1 -> READ, row=0, col=0.
- READ:
  - rd_en=1, rd_row=row, rd_col=col.
  - col<WEIGHT_COLS-1 -> col++ and stay in READ.
  - col==WEIGHT_COLS-1 -> DRAIN.
- Compare, on every cycle after a rd_en (internal 1-cycle valid delay):
  - Column 0 data loads max and idx=0 unconditionally.
  - Later columns update only if rd_data > max (signed, strict). Ties keep the lower index.
- DRAIN: rd_en=0; captures and compares the last column's data. -> WRITE.
- WRITE:
  - wr_en=1 for exactly 1 cycle; wr_addr=row; wr_data=idx, zero-extended to MAX_ADDRESS_WIDTH.
  - row==FEATURE_ROWS-1 -> DONE.
  - Otherwise row++, col=0 -> READ.
- DONE:
  - done=1, busy=0, strobes 0.
  - start=1 -> READ with row=0, col=0; done drops in the next cycle.
  - Otherwise stay in DONE.
- Timing:
  - Each row takes WEIGHT_COLS+2 cycles.
  - First READ is the cycle after the start sample.
  - DONE is entered FEATURE_ROWS*(WEIGHT_COLS+2) cycles after the first READ; 30 cycles at defaults.
- start while busy (READ/DRAIN/WRITE) is ignored; the pass is not restarted.
- rd_en and wr_en are never high in the same cycle.
- Reset mid-pass aborts immediately to IDLE with all outputs at reset values. Rows already written are not rolled back.
- Counters never exceed FEATURE_ROWS-1 / WEIGHT_COLS-1 and wrap to 0 only by explicit reload.
- Most-negative score (-32768 at defaults): with all columns equal to it, idx=0 (column-0 load rule).

Test Plan:
- Reset then start pulse, row scores {5,9,2} in all 6 rows -> six wr_en pulses, wr_data=1 each, wr_addr 0..5; done rises 30 cycles after first rd_en.
- Row 0 scores {7,7,7}, row 1 scores {-3,-1,-1} -> wr_data=0 for row 0 and wr_data=1 for row 1 (ties keep lower index, signed compare).
- Row scores {-32768,-32768,-32768} and {-5,32767,32767} -> wr_data=0 and wr_data=1 respectively.
- Hold start=1 throughout the pass -> no restart while busy; exactly 6 writes, then DONE; start still high in DONE -> second pass begins with row 0.
- Assert reset=0 during the WRITE of row 2 -> all outputs 0 in the same cycle, state IDLE; a new start processes rows 0..5 from scratch.
- Every cycle -> rd_en and wr_en are never both 1; rd_col stays in 0..2 and rd_row in 0..5.

Source files
------------

// File: rtl/argmax_readout_ctrl.sv
// rtl/argmax_readout_ctrl.sv - row-wise signed argmax sequencer over the FCC output matrix
// Reads each row's class scores, tracks the running maximum and writes the winning column index.
module argmax_readout_ctrl #(
  parameter int FEATURE_ROWS          = 6,
  parameter int WEIGHT_COLS           = 3,
  parameter int DOT_PROD_WIDTH        = 16,
  parameter int MAX_ADDRESS_WIDTH     = 2,
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
  parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             rd_en,
  output logic [COUNTER_FEATURE_WIDTH-1:0] rd_row,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]  rd_col,
  input  logic [DOT_PROD_WIDTH-1:0]        rd_data,
  output logic                             wr_en,
  output logic [COUNTER_FEATURE_WIDTH-1:0] wr_addr,
  output logic [MAX_ADDRESS_WIDTH-1:0]     wr_data,
  output logic                             busy,
  output logic                             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [COUNTER_FEATURE_WIDTH-1:0] ROW_LAST = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
  localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  COL_LAST = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);

  state_t                             state_q, state_d;
  logic [COUNTER_FEATURE_WIDTH-1:0]   row_q, row_d;
  logic [COUNTER_WEIGHT_WIDTH-1:0]    col_q, col_d;
  logic signed [DOT_PROD_WIDTH-1:0]   max_q, max_d;
  logic [COUNTER_WEIGHT_WIDTH-1:0]    idx_q, idx_d;
  // Read strobe and column delayed by the memory latency, so they line up with rd_data.
  logic                               vld_q;
  logic [COUNTER_WEIGHT_WIDTH-1:0]    vcol_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      vcol_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      vld_q   <= rd_en;
      vcol_q  <= col_q;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    rd_en   = 1'b0;
    rd_row  = '0;
    rd_col  = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          state_d = S_READ;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_READ: begin
        busy   = 1'b1;
        rd_en  = 1'b1;
        rd_row = row_q;
        rd_col = col_q;
        if (col_q == COL_LAST) state_d = S_DRAIN;
        else                   col_d   = col_q + COUNTER_WEIGHT_WIDTH'(1);
      end
      S_DRAIN: begin
        busy    = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = row_q;
        wr_data = MAX_ADDRESS_WIDTH'(idx_q);
        if (row_q == ROW_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
          row_d   = row_q + COUNTER_FEATURE_WIDTH'(1);
          col_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Column 0 always seeds the maximum; strict compare keeps the lowest index on ties.
  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    if (vld_q && ((vcol_q == '0) || ($signed(rd_data) > max_q))) begin
      max_d = $signed(rd_data);
      idx_d = vcol_q;
    end
  end

endmodule

// File: tb/tb_argmax_readout_ctrl.sv
// tb/tb_argmax_readout_ctrl.sv - randomized self-checking bench for argmax_readout_ctrl
module tb_argmax_readout_ctrl;
  localparam int FR = 6;
  localparam int WC = 3;
  localparam int PASS_CYCLES = FR * (WC + 2);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rd_en;
  logic [2:0]  rd_row;
  logic [1:0]  rd_col;
  logic [15:0] rd_data = '0;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [1:0]  wr_data;
  logic        busy;
  logic        done;

  argmax_readout_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .rd_en  (rd_en),
    .rd_row (rd_row),
    .rd_col (rd_col),
    .rd_data(rd_data),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  logic signed [15:0] mem [FR][WC];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int first_rd = -1;
  int done_cyc = -1;
  int wa[$];
  int wd[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_idx(input int r);
    int b = 0;
    for (int c = 1; c < WC; c++)
      if (mem[r][c] > mem[r][b]) b = c;
    return b;
  endfunction

  task automatic fill(input int mode);
    int pick;
    for (int r = 0; r < FR; r++)
      for (int c = 0; c < WC; c++) begin
        case (mode)
          0: mem[r][c] = 16'($urandom);
          1: mem[r][c] = 16'($urandom_range(0, 4) - 2);
          default: begin
            pick = $urandom_range(0, 3);
            mem[r][c] = (pick == 0) ? -16'sd32768 : (pick == 1) ? 16'sd32767 :
                        (pick == 2) ? 16'sd0 : -16'sd1;
          end
        endcase
      end
  endtask

  // FCC memory: data for a read issued in cycle k appears during cycle k+1.
  initial begin : fcc_mem
    logic       en_s;
    logic [2:0] r_s;
    logic [1:0] c_s;
    forever begin
      @(negedge clk);
      en_s = rd_en;
      r_s  = rd_row;
      c_s  = rd_col;
      @(posedge clk);
      #1;
      rd_data = en_s ? mem[r_s][c_s] : 16'($urandom);
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (rd_en && first_rd < 0) first_rd = cyc;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (wr_en) begin
        wa.push_back(int'(wr_addr));
        wd.push_back(int'(wr_data));
      end
      check("rd_wr_excl", 32'(rd_en & wr_en), 0);
      check("row_range", 32'(rd_row < 3'(FR)), 1);
      check("col_range", 32'(rd_col < 2'(WC)), 1);
    end
  end

  task automatic clear_obs();
    first_rd = -1;
    done_cyc = -1;
    wa.delete();
    wd.delete();
  endtask

  task automatic start_pass(input bit hold);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    clear_obs();
    check("busy_after_start", 32'(busy), 1);
  endtask

  task automatic wait_done_check(input string tag);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (done) break;
    end
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy_low"}, 32'(busy), 0);
    check({tag, "_latency"}, 32'(done_cyc - first_rd), PASS_CYCLES);
    check({tag, "_nwrites"}, 32'(wa.size()), FR);
    for (int i = 0; i < wa.size() && i < FR; i++) begin
      check({tag, "_wr_addr"}, 32'(wa[i]), i);
      check({tag, "_wr_data"}, 32'(wd[i]), exp_idx(i));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},   32'(rd_en), 0);
    check({tag, "_rd_row"},  32'(rd_row), 0);
    check({tag, "_rd_col"},  32'(rd_col), 0);
    check({tag, "_wr_en"},   32'(wr_en), 0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check({tag, "_wr_data"}, 32'(wr_data), 0);
    check({tag, "_busy"},    32'(busy), 0);
    check({tag, "_done"},    32'(done), 0);
  endtask

  initial begin : main
    bit found;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b1;

    for (int r = 0; r < FR; r++) begin
      mem[r][0] = 16'sd5; mem[r][1] = 16'sd9; mem[r][2] = 16'sd2;
    end
    start_pass(1'b0);
    wait_done_check("p592");

    fill(0);
    mem[0][0] = 16'sd7;    mem[0][1] = 16'sd7;     mem[0][2] = 16'sd7;
    mem[1][0] = -16'sd3;   mem[1][1] = -16'sd1;    mem[1][2] = -16'sd1;
    mem[2][0] = -16'sd32768; mem[2][1] = -16'sd32768; mem[2][2] = -16'sd32768;
    mem[3][0] = -16'sd5;   mem[3][1] = 16'sd32767; mem[3][2] = 16'sd32767;
    start_pass(1'b0);
    wait_done_check("ties");

    fill(1);
    start_pass(1'b1);
    wait_done_check("hold1");
    clear_obs();
    @(negedge clk);
    #1;
    check("restart_rd_en", 32'(rd_en), 1);
    check("restart_row", 32'(rd_row), 0);
    check("restart_done", 32'(done), 0);
    start = 1'b0;
    wait_done_check("hold2");

    for (int p = 0; p < 6; p++) begin
      fill(p % 3);
      start_pass(1'b0);
      wait_done_check("rand");
    end

    fill(0);
    start_pass(1'b0);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (wr_en && wr_addr == 3'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_write_row2", 32'(found), 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    reset = 1'b1;
    fill(1);
    start_pass(1'b0);
    wait_done_check("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
